// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data SRAM between the pipeline MEM
// stage (core) and a debug/loader port (host). Accepted requests go through
// a one-entry issue stage that drives the SRAM; read data comes back two
// cycles after grant. A saturating starvation counter forces a host grant
// after MAX_WAIT consecutive denied host cycles.
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration under
// contention; otherwise the core has fixed priority.

module dmem_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [31:0]           core_addr,
  input  logic [31:0]           core_wdata,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [31:0]           core_rdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [31:0]           host_addr,
  input  logic [31:0]           host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [31:0]           host_rdata,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH:0]   sram_addr,
  output logic [31:0]           sram_din,
  input  logic [31:0]           sram_dout
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0]            starve_cnt;
  logic                  prefer_host;
  logic                  force_host;
  logic                  pick_host;

  logic                  issue_valid;
  logic                  issue_host;
  logic                  issue_we;
  logic                  issue_oor;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [31:0]           issue_wdata;

  logic                  resp_valid;
  logic                  resp_host;
  logic                  resp_oor;
  logic [31:0]           resp_data;

  logic                  core_oor;
  logic                  host_oor;
  logic                  unused_addr_bits;

  // Word access only: the byte-offset bits are deliberately not looked at.
  assign unused_addr_bits = ^{core_addr[1:0], host_addr[1:0]};

  assign core_oor   = (core_addr[31:ADDR_WIDTH+2] != '0);
  assign host_oor   = (host_addr[31:ADDR_WIDTH+2] != '0);
  assign force_host = host_req && (starve_cnt == WAIT_LIMIT);

  // Pick the winner from current requests; starvation override beats mode.
  always_comb begin
    pick_host = 1'b0;
    if (host_req) begin
      if (!core_req || force_host)
        pick_host = 1'b1;
      else
        pick_host = prefer_host;
    end
    core_gnt = ~rst & core_req & ~pick_host;
    host_gnt = ~rst & host_req & pick_host;
  end

  // Count consecutive cycles the host asked and lost, saturating at 15.
  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= 4'd0;
    else if (!host_req || host_gnt)
      starve_cnt <= 4'd0;
    else if (starve_cnt != 4'hF)
      starve_cnt <= starve_cnt + 4'd1;
  end

`ifdef DMEM_ARB_RR_EN
  // Round-robin pointer: after a contended grant, favour the other side.
  always_ff @(posedge clk) begin
    if (rst)
      prefer_host <= 1'b0;
    else if (core_req && host_req && (core_gnt || host_gnt))
      prefer_host <= core_gnt;
  end
`else
  assign prefer_host = 1'b0;
`endif

  // Capture the accepted request so it can drive the SRAM next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid <= 1'b0;
      issue_host  <= 1'b0;
      issue_we    <= 1'b0;
      issue_oor   <= 1'b0;
      issue_addr  <= '0;
      issue_wdata <= '0;
    end else begin
      issue_valid <= core_gnt | host_gnt;
      issue_host  <= host_gnt;
      if (host_gnt) begin
        issue_we    <= host_we;
        issue_oor   <= host_oor;
        issue_addr  <= host_addr[ADDR_WIDTH+1:2];
        issue_wdata <= host_wdata;
      end else begin
        issue_we    <= core_we;
        issue_oor   <= core_oor;
        issue_addr  <= core_addr[ADDR_WIDTH+1:2];
        issue_wdata <= core_wdata;
      end
    end
  end

  // Out-of-range accesses and the reset cycle never touch the SRAM.
  assign sram_csb  = rst | ~issue_valid | issue_oor;
  assign sram_web  = rst | ~issue_valid | issue_oor | ~issue_we;
  assign sram_addr = {1'b0, issue_addr};
  assign sram_din  = issue_wdata;

  // Track which read is being answered by the SRAM output this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_host  <= 1'b0;
      resp_oor   <= 1'b0;
    end else begin
      resp_valid <= issue_valid & ~issue_we;
      resp_host  <= issue_host;
      resp_oor   <= issue_oor;
    end
  end

  assign resp_data   = resp_oor ? 32'h0 : sram_dout;
  assign core_rvalid = ~rst & resp_valid & ~resp_host;
  assign host_rvalid = ~rst & resp_valid & resp_host;
  assign core_rdata  = core_rvalid ? resp_data : 32'h0;
  assign host_rdata  = host_rvalid ? resp_data : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural
// SRAM, a random phase against an order-based reference model, a directed
// vector table, and hand-written contention and reset sequences.

module tb_dmem_arbiter;

  localparam int AW = 5;
  localparam int MW = 4;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we, core_gnt, core_rvalid;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        host_req, host_we, host_gnt, host_rvalid;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic        sram_csb, sram_web;
  logic [AW:0] sram_addr;
  logic [31:0] sram_din;
  logic [31:0] sram_dout = 32'h0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  typedef struct {
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        hr, hw;
    logic [31:0] ha, hd;
    logic        ecg, ehg, ecrv;
    logic [31:0] ecrd;
    logic        ehrv;
    logic [31:0] ehrd;
    logic        ecsb;
  } vec_t;

  typedef struct {
    int          due;
    logic        host;
    logic [31:0] data;
  } resp_t;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  function automatic logic [31:0] initWord(int i);
    return 32'h1234_0000 + 32'(i) * 32'h0001_0003;
  endfunction

  // Synchronous single-port SRAM: output register updates only on reads.
  logic [31:0] mem [64];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) mem[i] <= initWord(i);
      mem_ready <= 1'b1;
    end else if (!sram_csb) begin
      if (!sram_web) mem[sram_addr] <= sram_din;
      else           sram_dout <= mem[sram_addr];
    end
  end

  task automatic checkBit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input req_t c, input req_t h);
    core_req = c.req; core_we = c.we; core_addr = c.addr; core_wdata = c.data;
    host_req = h.req; host_we = h.we; host_addr = h.addr; host_wdata = h.data;
  endtask

  function automatic req_t mkReq(logic r, logic w, logic [31:0] a, logic [31:0] d);
    req_t q;
    q.req = r; q.we = w; q.addr = a; q.data = d;
    return q;
  endfunction

  task automatic driveIdle();
    applyStimulus(mkReq(F, F, 32'h0, 32'h0), mkReq(F, F, 32'h0, 32'h0));
  endtask

  task automatic doReset();
    rst = 1'b1;
    driveIdle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic checkVec(input vec_t v, input string tag);
    @(negedge clk);
    checkBit({tag, ".core_gnt"}, core_gnt, v.ecg);
    checkBit({tag, ".host_gnt"}, host_gnt, v.ehg);
    checkBit({tag, ".core_rvalid"}, core_rvalid, v.ecrv);
    checkOutput({tag, ".core_rdata"}, core_rdata, v.ecrd);
    checkBit({tag, ".host_rvalid"}, host_rvalid, v.ehrv);
    checkOutput({tag, ".host_rdata"}, host_rdata, v.ehrd);
    checkBit({tag, ".sram_csb"}, sram_csb, v.ecsb);
  endtask

  function automatic req_t randReq();
    req_t q;
    q.req  = 1'b1;
    q.we   = 1'($urandom_range(0, 1));
    q.addr = (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 7) == 0)
      q.addr = q.addr | (32'h1 << $urandom_range(AW + 2, 31));
    q.data = $urandom;
    return q;
  endfunction

  // Reference model state for the random phase.
  logic [31:0] ref_mem [32];
  resp_t       expq[$];

  task automatic randomPhase(input int cycles);
    req_t  cp, hp;
    int    wait_cnt;
    bit    pref_host, prev_access, next_access;
    bit    host_win, exp_cg, exp_hg, head_due;
    req_t  g;
    resp_t r;
    int    word;
    bit    oor;
    cp = mkReq(F, F, 32'h0, 32'h0);
    hp = mkReq(F, F, 32'h0, 32'h0);
    wait_cnt = 0; pref_host = 0; prev_access = 0;
    expq.delete();
    for (int cyc = 0; cyc < cycles; cyc++) begin
      if (!cp.req && $urandom_range(0, 3) != 0) cp = randReq();
      if (!hp.req && $urandom_range(0, 3) != 0) hp = randReq();
      applyStimulus(cp, hp);
      host_win = hp.req && (!cp.req || wait_cnt == MW || (RR && pref_host));
      exp_hg = host_win;
      exp_cg = cp.req && !host_win;
      head_due = (expq.size() > 0) && (expq[0].due == cyc);
      @(negedge clk);
      checkBit("rnd.core_gnt", core_gnt, exp_cg);
      checkBit("rnd.host_gnt", host_gnt, exp_hg);
      checkBit("rnd.core_rvalid", core_rvalid, head_due && !expq[0].host);
      checkBit("rnd.host_rvalid", host_rvalid, head_due && expq[0].host);
      checkOutput("rnd.core_rdata", core_rdata, (head_due && !expq[0].host) ? expq[0].data : 32'h0);
      checkOutput("rnd.host_rdata", host_rdata, (head_due && expq[0].host) ? expq[0].data : 32'h0);
      checkBit("rnd.sram_csb", sram_csb, !prev_access);
      if (head_due) void'(expq.pop_front());
      next_access = 0;
      if (exp_cg || exp_hg) begin
        g = exp_hg ? hp : cp;
        oor  = (g.addr >> (AW + 2)) != 0;
        word = int'((g.addr >> 2) % 32);
        if (!g.we) begin
          r.due = cyc + 2; r.host = exp_hg; r.data = oor ? 32'h0 : ref_mem[word];
          expq.push_back(r);
        end else if (!oor) begin
          ref_mem[word] = g.data;
        end
        next_access = !oor;
      end
      if (!hp.req || exp_hg) wait_cnt = 0;
      else if (wait_cnt < 15) wait_cnt++;
      if (cp.req && hp.req) pref_host = exp_cg;
      if (exp_cg) cp.req = 1'b0;
      if (exp_hg) hp.req = 1'b0;
      prev_access = next_access;
      tick();
    end
  endtask

  vec_t tbl [21];

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = initWord(i);

    // Reset state with both requests raised: no grants, SRAM idle.
    rst = 1'b1;
    applyStimulus(mkReq(T, F, 32'h10, 32'h0), mkReq(T, T, 32'h4, 32'h1));
    tick();
    tick();
    @(negedge clk);
    checkBit("rst.core_gnt", core_gnt, 1'b0);
    checkBit("rst.host_gnt", host_gnt, 1'b0);
    checkBit("rst.core_rvalid", core_rvalid, 1'b0);
    checkBit("rst.host_rvalid", host_rvalid, 1'b0);
    checkOutput("rst.core_rdata", core_rdata, 32'h0);
    checkOutput("rst.host_rdata", host_rdata, 32'h0);
    checkBit("rst.sram_csb", sram_csb, 1'b1);
    checkBit("rst.sram_web", sram_web, 1'b1);
    tick();
    rst = 1'b0;

    randomPhase(600);

    // Directed vectors: expected outputs for each cycle given its inputs.
    tbl[0]  = '{T,T,32'h10,32'hDEADBEEF, F,F,32'h0,32'h0,     T,F, F,32'h0,        F,32'h0,        T};
    tbl[1]  = '{T,F,32'h10,32'h0,        F,F,32'h0,32'h0,     T,F, F,32'h0,        F,32'h0,        F};
    tbl[2]  = '{F,F,32'h0,32'h0,         F,F,32'h0,32'h0,     F,F, F,32'h0,        F,32'h0,        F};
    tbl[3]  = '{F,F,32'h0,32'h0,         F,F,32'h0,32'h0,     F,F, T,32'hDEADBEEF, F,32'h0,        T};
    tbl[4]  = '{T,T,32'h0C,32'h33,       F,F,32'h0,32'h0,     T,F, F,32'h0,        F,32'h0,        T};
    tbl[5]  = '{T,F,32'h0C,32'h0,        F,F,32'h0,32'h0,     T,F, F,32'h0,        F,32'h0,        F};
    tbl[6]  = '{F,F,32'h0,32'h0,         T,T,32'h0C,32'h5,    F,T, F,32'h0,        F,32'h0,        F};
    tbl[7]  = '{F,F,32'h0,32'h0,         F,F,32'h0,32'h0,     F,F, T,32'h33,       F,32'h0,        F};
    tbl[8]  = '{T,F,32'h0E,32'h0,        F,F,32'h0,32'h0,     T,F, F,32'h0,        F,32'h0,        T};
    tbl[9]  = '{F,F,32'h0,32'h0,         F,F,32'h0,32'h0,     F,F, F,32'h0,        F,32'h0,        F};
    tbl[10] = '{F,F,32'h0,32'h0,         F,F,32'h0,32'h0,     F,F, T,32'h5,        F,32'h0,        T};
    tbl[11] = '{F,F,32'h0,32'h0,         T,F,32'h100,32'h0,   F,T, F,32'h0,        F,32'h0,        T};
    tbl[12] = '{F,F,32'h0,32'h0,         F,F,32'h0,32'h0,     F,F, F,32'h0,        F,32'h0,        T};
    tbl[13] = '{F,F,32'h0,32'h0,         F,F,32'h0,32'h0,     F,F, F,32'h0,        T,32'h0,        T};
    tbl[14] = '{F,F,32'h0,32'h0,         T,F,32'h13,32'h0,    F,T, F,32'h0,        F,32'h0,        T};
    tbl[15] = '{F,F,32'h0,32'h0,         F,F,32'h0,32'h0,     F,F, F,32'h0,        F,32'h0,        F};
    tbl[16] = '{F,F,32'h0,32'h0,         F,F,32'h0,32'h0,     F,F, F,32'h0,        T,32'hDEADBEEF, T};
    tbl[17] = '{T,F,32'h10,32'h0,        T,F,32'h0C,32'h0,    T,F, F,32'h0,        F,32'h0,        T};
    tbl[18] = '{F,F,32'h0,32'h0,         T,F,32'h0C,32'h0,    F,T, F,32'h0,        F,32'h0,        F};
    tbl[19] = '{F,F,32'h0,32'h0,         F,F,32'h0,32'h0,     F,F, T,32'hDEADBEEF, F,32'h0,        F};
    tbl[20] = '{F,F,32'h0,32'h0,         F,F,32'h0,32'h0,     F,F, F,32'h0,        T,32'h5,        T};

    doReset();
    for (int i = 0; i < 21; i++) begin
      applyStimulus(mkReq(tbl[i].cr, tbl[i].cw, tbl[i].ca, tbl[i].cd),
                    mkReq(tbl[i].hr, tbl[i].hw, tbl[i].ha, tbl[i].hd));
      checkVec(tbl[i], $sformatf("vec%0d", i));
      tick();
    end

    // Both sides requesting continuously for ten cycles.
    doReset();
    for (int i = 0; i < 10; i++) begin
      bit exp_host;
      exp_host = RR ? (i % 2 == 1) : (i == 4 || i == 9);
      applyStimulus(mkReq(T, F, 32'h0, 32'h0), mkReq(T, F, 32'h4, 32'h0));
      @(negedge clk);
      checkBit($sformatf("cont%0d.core_gnt", i), core_gnt, !exp_host);
      checkBit($sformatf("cont%0d.host_gnt", i), host_gnt, exp_host);
      tick();
    end

    // Reset arriving right after a granted read discards it.
    doReset();
    applyStimulus(mkReq(T, F, 32'h10, 32'h0), mkReq(F, F, 32'h0, 32'h0));
    @(negedge clk);
    checkBit("rstmid.grant", core_gnt, 1'b1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    checkBit("rstmid.gnt_in_rst", core_gnt, 1'b0);
    checkBit("rstmid.csb_in_rst", sram_csb, 1'b1);
    checkBit("rstmid.rvalid_in_rst", core_rvalid, 1'b0);
    tick();
    rst = 1'b0;
    driveIdle();
    @(negedge clk);
    checkBit("rstmid.csb_after", sram_csb, 1'b1);
    checkBit("rstmid.rvalid_after", core_rvalid, 1'b0);
    tick();
    @(negedge clk);
    checkBit("rstmid.rvalid_later", core_rvalid, 1'b0);
    checkBit("rstmid.hrvalid_later", host_rvalid, 1'b0);
    checkBit("rstmid.csb_later", sram_csb, 1'b1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
